// File: rtl/crossbar_rotation_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : crossbar_rotation_scheduler
// Purpose  : Round-robin scheduler for the shared word-rotating barrel shifter
//            of an NxN crossbar. Each cycle one rotation amount is selected.
//            Every input whose destination matches that rotation is accepted.
//            The captured bus and the shift amount are registered. A
//            one-slot-per-port output stage applies per-output backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module crossbar_rotation_scheduler #(
    parameter int N       = 8,
    parameter int W       = 8,
    parameter int SHIFT_W = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           in_valid,
    input  logic [N*SHIFT_W-1:0]   in_dest,
    input  logic [N*W-1:0]         in_bus,
    output logic [N-1:0]           in_ready,
    output logic [N*W-1:0]         cap_bus,
    output logic [SHIFT_W-1:0]     sh_shift,
    output logic [N-1:0]           out_valid,
    input  logic [N-1:0]           out_ready
);

    // Reduce a value in [0, 2N) to [0, N). Every caller keeps its operand
    // inside that range, so a single conditional subtract is enough.
    function automatic int wrap_n(input int v);
        return (v >= N) ? (v - N) : v;
    endfunction

    // Inputs that would land on their own destination under rotation s.
    // Input i lands at output (i - s) mod N. The subtraction is done as
    // i + N - s so that it never underflows. A destination >= N (only
    // possible when N is not a power of two) can never equal a value < N,
    // so such an input simply never matches.
    function automatic logic [N-1:0] match_for(
        input int                     s,
        input logic [N-1:0]           vld,
        input logic [N*SHIFT_W-1:0]   dst
    );
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            m[i] = vld[i] && (dst[i*SHIFT_W +: SHIFT_W] == SHIFT_W'(wrap_n(i + N - s)));
        end
        return m;
    endfunction

    logic [SHIFT_W-1:0] ptr_q, ptr_d;
    logic [SHIFT_W-1:0] sh_shift_q, sh_shift_d;
    logic [N*W-1:0]     cap_bus_q, cap_bus_d;
    logic [N-1:0]       out_valid_q, out_valid_d;

    logic               stage_free;
    logic               found;
    logic [SHIFT_W-1:0] sel;
    logic [N-1:0]       sel_match;
    logic [N-1:0]       cand_match;
    logic [N-1:0]       grant;
    logic               accept;
    logic [2*N-1:0]     grant_rot;

    // The output stage may take a new decision when every slot is empty or
    // is being consumed in this same cycle.
    assign stage_free = &(~out_valid_q | out_ready);

    // Round-robin search: first rotation from ptr onward with any matching input.
    always_comb begin
        found      = 1'b0;
        sel        = '0;
        sel_match  = '0;
        cand_match = '0;
        for (int k = 0; k < N; k++) begin
            cand_match = match_for(wrap_n(int'(ptr_q) + k), in_valid, in_dest);
            if (!found && (cand_match != '0)) begin
                found     = 1'b1;
                sel       = SHIFT_W'(wrap_n(int'(ptr_q) + k));
                sel_match = cand_match;
            end
        end
    end

    // Grants are withheld while reset is asserted and while the stage is busy.
    assign grant    = (rst_n && stage_free) ? sel_match : '0;
    assign accept   = |grant;
    assign in_ready = grant;

    // Output slot j is filled by input (j + sel) mod N. Rotating the grant
    // vector right by sel through a doubled copy yields that mapping directly.
    assign grant_rot = {grant, grant} >> sel;

    // Next state: load a new decision on accept, otherwise drain individual slots.
    always_comb begin
        ptr_d       = ptr_q;
        sh_shift_d  = sh_shift_q;
        cap_bus_d   = cap_bus_q;
        out_valid_d = out_valid_q & ~out_ready;
        if (accept) begin
            ptr_d       = SHIFT_W'(wrap_n(int'(sel) + 1));
            sh_shift_d  = sel;
            cap_bus_d   = in_bus;
            out_valid_d = grant_rot[N-1:0];
        end
    end

    // State registers; reset drops any pending output words immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            sh_shift_q  <= '0;
            cap_bus_q   <= '0;
            out_valid_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            sh_shift_q  <= sh_shift_d;
            cap_bus_q   <= cap_bus_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign cap_bus   = cap_bus_q;
    assign sh_shift  = sh_shift_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire
